// File: rtl/ro_puf_pkg.sv
// Shared types and default sizing for the ring-oscillator race counter and
// the downstream PUF response logic.
package ro_puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } race_state_e;

  localparam int DEF_N_CH  = 8;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_TO_W  = 24;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchroniser for one asynchronous ring-oscillator output, plus a
// single-cycle pulse on each synchronised 0->1 transition.
module ro_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/ro_race_counter.sv
// Races N_CH ring oscillators: the first channel to collect `threshold`
// synchronised rising edges wins, unless the cycle budget runs out first.
module ro_race_counter import ro_puf_pkg::*; #(
  parameter  int N_CH  = DEF_N_CH,
  parameter  int CNT_W = DEF_CNT_W,
  parameter  int TO_W  = DEF_TO_W,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] threshold,
  input  logic [TO_W-1:0]  timeout_cyc,
  input  logic [N_CH-1:0]  ro_in,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] winner,
  output logic             tie,
  output logic             timed_out
);

  localparam int PC_W = $clog2(N_CH + 1);

  race_state_e      state_q, state_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [TO_W-1:0]  to_lim_q, to_lim_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic             tie_q, tie_d;
  logic             timed_out_q, timed_out_d;

  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  hit;
  logic             running;
  logic             accept;
  logic             win_any;
  logic [IDX_W-1:0] win_idx;
  logic [PC_W-1:0]  hit_cnt;

  assign running = (state_q == ST_RUN);
  assign accept  = start && (state_q != ST_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;

      ro_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ro_in[gi]),
        .rise     (rise[gi])
      );

      // A hit is the edge that brings the count up to threshold; the race
      // resolves on the same clock the counter would take that value.
      assign hit[gi] = running && rise[gi] && (cnt_q == thr_q - CNT_W'(1));

      always_comb begin
        cnt_d = cnt_q;
        if (accept)
          cnt_d = '0;
        else if (running && rise[gi] && (cnt_q < thr_q))
          cnt_d = cnt_q + CNT_W'(1);
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
    end
  endgenerate

  // Lowest-index winner and a count of simultaneous hits for the tie flag.
  always_comb begin
    win_idx = '0;
    hit_cnt = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (hit[i]) win_idx = IDX_W'(i);
    end
    for (int i = 0; i < N_CH; i++) begin
      hit_cnt = hit_cnt + PC_W'(hit[i]);
    end
    win_any = |hit;
  end

  always_comb begin
    state_d     = state_q;
    thr_d       = thr_q;
    to_lim_d    = to_lim_q;
    to_cnt_d    = to_cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    winner_d    = winner_q;
    tie_d       = tie_q;
    timed_out_d = timed_out_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          thr_d       = (threshold == '0) ? CNT_W'(1) : threshold;
          to_lim_d    = timeout_cyc;
          to_cnt_d    = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          winner_d    = '0;
          tie_d       = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      ST_RUN: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // A win in the same cycle as the budget expiring still counts.
        if (win_any) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          winner_d    = win_idx;
          tie_d       = (hit_cnt > PC_W'(1));
          timed_out_d = 1'b0;
        end else if ((to_lim_q != '0) && (to_cnt_q == to_lim_q)) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          winner_d    = '0;
          tie_d       = 1'b0;
          timed_out_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      thr_q       <= CNT_W'(1);
      to_lim_q    <= '0;
      to_cnt_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      winner_q    <= '0;
      tie_q       <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      to_lim_q    <= to_lim_d;
      to_cnt_q    <= to_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      winner_q    <= winner_d;
      tie_q       <= tie_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign winner    = winner_q;
  assign tie       = tie_q;
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_ro_race_counter.sv
// Directed bench for ro_race_counter with four channels: a per-cycle vector
// table plus hand-written multi-cycle race, timeout and reset sequences.
module tb_ro_race_counter;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int TO_W  = 24;
  localparam int IDX_W = 2;
  localparam int NVEC  = 22;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] threshold;
  logic [TO_W-1:0]  timeout_cyc;
  logic [N_CH-1:0]  ro_in;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] winner;
  logic             tie;
  logic             timed_out;

  always #5 clk = ~clk;

  ro_race_counter #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W),
    .TO_W  (TO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .threshold   (threshold),
    .timeout_cyc (timeout_cyc),
    .ro_in       (ro_in),
    .busy        (busy),
    .done        (done),
    .winner      (winner),
    .tie         (tie),
    .timed_out   (timed_out)
  );

  typedef struct {
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] thr;
    logic [TO_W-1:0]  tcyc;
    logic [N_CH-1:0]  ro;
    logic [5:0]       exp; // {busy, done, winner[1:0], tie, timed_out}
  } vec_t;

  vec_t vecs [NVEC];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {busy, done, winner, tie, timed_out};
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input int thr, input int tc,
                              input logic [N_CH-1:0] ro, input logic [5:0] exp);
    vec_t v;
    v.rst = r; v.start = s; v.thr = CNT_W'(thr); v.tcyc = TO_W'(tc); v.ro = ro; v.exp = exp;
    return v;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; threshold = '0; timeout_cyc = '0; ro_in = '0;

    //                r  s  thr tc  ro        b d win t o
    vecs[0]  = mk(1, 0, 0, 0, 4'b0000, 6'b0_0_00_0_0);
    vecs[1]  = mk(0, 1, 0, 0, 4'b0000, 6'b1_0_00_0_0); // threshold 0 -> 1
    vecs[2]  = mk(0, 0, 0, 0, 4'b0100, 6'b1_0_00_0_0);
    vecs[3]  = mk(0, 0, 0, 0, 4'b0100, 6'b1_0_00_0_0);
    vecs[4]  = mk(0, 0, 0, 0, 4'b0100, 6'b0_1_10_0_0); // ch2 wins, one clock after sync edge
    vecs[5]  = mk(0, 0, 0, 0, 4'b0000, 6'b0_1_10_0_0);
    vecs[6]  = mk(0, 1, 1, 3, 4'b0000, 6'b1_0_00_0_0); // re-arm from DONE
    vecs[7]  = mk(0, 0, 1, 3, 4'b0000, 6'b1_0_00_0_0);
    vecs[8]  = mk(0, 0, 1, 3, 4'b0000, 6'b1_0_00_0_0);
    vecs[9]  = mk(0, 0, 1, 3, 4'b0000, 6'b1_0_00_0_0);
    vecs[10] = mk(0, 0, 1, 3, 4'b0000, 6'b0_1_00_0_1); // timeout at cycle 4
    vecs[11] = mk(0, 1, 2, 0, 4'b0000, 6'b1_0_00_0_0);
    vecs[12] = mk(0, 1, 1, 0, 4'b0000, 6'b1_0_00_0_0); // start in RUN ignored
    vecs[13] = mk(0, 0, 1, 0, 4'b1010, 6'b1_0_00_0_0);
    vecs[14] = mk(0, 0, 1, 0, 4'b1010, 6'b1_0_00_0_0);
    vecs[15] = mk(0, 0, 1, 0, 4'b0000, 6'b1_0_00_0_0); // ch1/ch3 count 1 of 2
    vecs[16] = mk(0, 0, 1, 0, 4'b0000, 6'b1_0_00_0_0);
    vecs[17] = mk(0, 0, 1, 0, 4'b1010, 6'b1_0_00_0_0);
    vecs[18] = mk(0, 0, 1, 0, 4'b1010, 6'b1_0_00_0_0);
    vecs[19] = mk(0, 0, 1, 0, 4'b1010, 6'b0_1_01_1_0); // tie, lowest index 1
    vecs[20] = mk(1, 1, 1, 0, 4'b0000, 6'b0_0_00_0_0); // reset beats start
    vecs[21] = mk(0, 0, 1, 0, 4'b0000, 6'b0_0_00_0_0);

    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; threshold = vecs[i].thr;
      timeout_cyc = vecs[i].tcyc; ro_in = vecs[i].ro;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Race, threshold 10: ch2 toggles every cycle, the others far slower.
    begin
      int c;
      start = 1'b1; threshold = 16'd10; timeout_cyc = 24'd1000; ro_in = '0;
      tick();
      start = 1'b0;
      for (c = 0; c < 300 && !done; c++) begin
        ro_in[2] = ~ro_in[2];
        if (c % 3 == 0) ro_in[0] = ~ro_in[0];
        if (c % 4 == 0) ro_in[1] = ~ro_in[1];
        if (c % 5 == 0) ro_in[3] = ~ro_in[3];
        tick();
      end
      check("race_done", 32'(done), 32'(1));
      check("race_winner", 32'(winner), 32'(2));
      check("race_tie", 32'(tie), 32'(0));
      check("race_timeout", 32'(timed_out), 32'(0));
    end

    ro_in = '0;
    repeat (4) tick();

    // Timeout of 100 with all inputs quiet: done on the 101st edge after start.
    begin
      int early = 0;
      start = 1'b1; threshold = 16'd5; timeout_cyc = 24'd100;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 100; k++) begin
        tick();
        if (done) early++;
      end
      check("to_early_done", 32'(early), 32'(0));
      check("to_busy_c100", 32'(busy), 32'(1));
      tick();
      check("to_outs_c101", 32'(outs()), 32'(6'b0_1_00_0_1));
    end

    // Mid-race start pulse with a lower threshold must not be taken.
    start = 1'b1; threshold = 16'd2; timeout_cyc = '0;
    tick();
    threshold = 16'd1;
    tick();
    start = 1'b0; ro_in = 4'b0001;
    repeat (4) tick();
    check("ign_start_outs", 32'(outs()), 32'(6'b1_0_00_0_0));

    // Reset mid-race with ch0 held high: synchroniser is cleared, so the held
    // level shows up as a fresh rising edge for the next race.
    rst = 1'b1;
    tick();
    check("rst_mid_outs", 32'(outs()), 32'(6'b0_0_00_0_0));
    rst = 1'b0; start = 1'b1; threshold = '0;
    tick();
    check("post_rst_busy", 32'(busy), 32'(1));
    start = 1'b0;
    tick();
    check("post_rst_wait", 32'(done), 32'(0));
    tick();
    check("post_rst_win", 32'(outs()), 32'(6'b0_1_00_0_0));

    // Re-arm straight from DONE.
    start = 1'b1; threshold = 16'd3;
    tick();
    start = 1'b0;
    check("rearm_outs", 32'(outs()), 32'(6'b1_0_00_0_0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
